// File: rtl/rv32i_wb_data_mem_responder.sv
// Wishbone B4 pipelined data-memory responder for the RV32I superscalar bench.
// Byte-lane writes, in-order ack/err after ACK_LATENCY cycles, optional injected stalls.
module rv32i_wb_data_mem_responder #(
   parameter int unsigned MEM_WORDS    = 4096,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned ACK_LATENCY  = 1,
   parameter int unsigned RESP_DEPTH   = 4,
   parameter int unsigned STALL_PERIOD = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic        wb_stall_o,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        wb_err_o
);
   localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int unsigned STL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

   logic [31:0]      mem_q [MEM_WORDS] = '{default: 32'h0000_0000};
   logic             q_err_q [RESP_DEPTH];
   logic [31:0]      q_dat_q [RESP_DEPTH];
   logic [3:0]       q_due_q [RESP_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]       tick_q, tick_d;
   logic [STL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             ack_q, ack_d, err_q, err_d;
   logic [31:0]      dat_q, dat_d;
   logic [29:0]      word_s;
   logic [IDX_W-1:0] idx_s;
   logic             req_err_s;
   logic [31:0]      rdata_s;
   logic             inject_s, pop_s, stall_s, accept_s;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(RESP_DEPTH - 1)) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   // Address decode and read data as seen at the accept edge.
   always_comb begin
      word_s    = wb_adr_i[31:2] - BASE_ADDR[31:2];
      idx_s     = word_s[IDX_W-1:0];
      req_err_s = (wb_adr_i < BASE_ADDR) || (word_s >= 30'(MEM_WORDS)) ||
                  (wb_adr_i[1:0] != 2'b00);
      if (req_err_s || wb_we_i) begin
         rdata_s = 32'h0000_0000;
      end else begin
         rdata_s = mem_q[idx_s];
      end
   end

   // A head entry leaving this cycle frees its slot for a same-edge accept.
   assign inject_s   = (STALL_PERIOD != 0) && (stall_cnt_q == STL_W'(STALL_PERIOD - 1));
   assign pop_s      = (count_q != CNT_W'(0)) && (q_due_q[rd_ptr_q] == tick_q);
   assign stall_s    = ((count_q == CNT_W'(RESP_DEPTH)) && !pop_s) || inject_s;
   assign accept_s   = wb_cyc_i && wb_stb_i && !stall_s;
   assign wb_stall_o = stall_s;
   assign wb_ack_o   = ack_q;
   assign wb_err_o   = err_q;
   assign wb_dat_o   = dat_q;

   // Next-state for queue pointers, occupancy, stall counter and response outputs.
   always_comb begin
      tick_d   = tick_q + 4'd1;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = 32'h0000_0000;
      if ((STALL_PERIOD == 0) || inject_s) begin
         stall_cnt_d = '0;
      end else begin
         stall_cnt_d = stall_cnt_q + STL_W'(1);
      end
      if (!wb_cyc_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (accept_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            ack_d    = !q_err_q[rd_ptr_q];
            err_d    = q_err_q[rd_ptr_q];
            dat_d    = q_dat_q[rd_ptr_q];
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q      <= 4'd0;
         stall_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         dat_q       <= 32'h0000_0000;
      end else begin
         tick_q      <= tick_d;
         stall_cnt_q <= stall_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         dat_q       <= dat_d;
      end
   end

   // Response queue storage; the due tick is compared against tick_q for release.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         q_err_q[wr_ptr_q] <= req_err_s;
         q_dat_q[wr_ptr_q] <= rdata_s;
         q_due_q[wr_ptr_q] <= tick_q + 4'(ACK_LATENCY);
      end
   end

   // Memory array, deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (accept_s && wb_we_i && !req_err_s && !rst) begin
         mem_q[idx_s] <= merge_lanes(mem_q[idx_s], wb_dat_i, wb_sel_i);
      end
   end
endmodule
